// File: rtl/cpu_pkg.sv
// Shared constants for the RISC core control path: widths, opcodes, sequencer states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 13;
  localparam int OP_W   = 3;

  // Sequencer states; S0..S7 are consecutive so a waveform reads as a phase count
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_S0     = 4'd1,
    ST_S1     = 4'd2,
    ST_S2     = 4'd3,
    ST_S3     = 4'd4,
    ST_S4     = 4'd5,
    ST_S5     = 4'd6,
    ST_S6     = 4'd7,
    ST_S7     = 4'd8,
    ST_HALTED = 4'd9
  } state_t;

  localparam logic [OP_W-1:0] OP_HLT  = 3'd0;
  localparam logic [OP_W-1:0] OP_SKZ  = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 3'd2;
  localparam logic [OP_W-1:0] OP_ANDD = 3'd3;
  localparam logic [OP_W-1:0] OP_XORR = 3'd4;
  localparam logic [OP_W-1:0] OP_LDA  = 3'd5;
  localparam logic [OP_W-1:0] OP_STO  = 3'd6;
  localparam logic [OP_W-1:0] OP_JMP  = 3'd7;

  // Opcodes that read an operand from memory into the accumulator path
  function automatic logic is_alu(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Control/data bundle between the sequencer and the rest of the core.
// Latency: none, wires only.
// Backpressure: none; the sequencer free-runs once enabled.
interface cpu_controller_if #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int OP_W   = cpu_pkg::OP_W
);
  logic              ena;
  logic [DATA_W-1:0] data_in;
  logic              zero;
  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] ir_addr;
  logic              inc_pc;
  logic              load_pc;
  logic              rd;
  logic              wr;
  logic              load_acc;
  logic              datactl_ena;
  logic              addr_sel;
  logic              halt;

  modport master (
    input  ena, data_in, zero,
    output opcode, ir_addr, inc_pc, load_pc, rd, wr, load_acc, datactl_ena, addr_sel, halt
  );

  modport slave (
    output ena, data_in, zero,
    input  opcode, ir_addr, inc_pc, load_pc, rd, wr, load_acc, datactl_ena, addr_sel, halt
  );
endinterface

// File: rtl/cpu_controller_instr_reg.sv
// Instruction register: 16-bit word assembled from two data-bus bytes, high byte first.
// Latency: each byte visible one cycle after its load strobe.
// Backpressure: none; loads whenever a strobe is high.
module instr_reg #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ld_hi,
  input  logic                i_ld_lo,
  input  logic [DATA_W-1:0]   i_data_in,
  output logic [2*DATA_W-1:0] o_ir
);

  logic [2*DATA_W-1:0] r_ir;

  // Byte-select load; the two strobes come from different sequencer phases
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir <= '0;
    end else begin
      if (i_ld_hi) r_ir[2*DATA_W-1:DATA_W] <= i_data_in;
      if (i_ld_lo) r_ir[DATA_W-1:0]        <= i_data_in;
    end
  end

  assign o_ir = r_ir;

endmodule

// File: rtl/cpu_controller.sv
// Instruction fetch/decode sequencer: 8 phases per instruction, outputs decoded from state.
// Latency: one instruction per 8 cycles; IDLE->S0 one cycle after ena.
// Backpressure: none; ena is only honoured in IDLE and S7, HLT parks until reset.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int OP_W   = cpu_pkg::OP_W
) (
  input  logic              clk,
  input  logic              rst,
  cpu_controller_if.master  bus
);

  state_t                r_state;
  state_t                w_next;
  logic                  r_zero_q;
  logic [2*DATA_W-1:0]   w_ir;
  logic [OP_W-1:0]       w_op;
  logic                  w_alu;
  logic                  w_sto;
  logic                  w_jmp;
  logic                  w_skz_taken;
  logic                  w_inc_pc, w_load_pc, w_rd, w_wr;
  logic                  w_load_acc, w_datactl_ena, w_addr_sel, w_halt;

  instr_reg #(.DATA_W(DATA_W)) u_ir (
    .clk       (clk),
    .rst       (rst),
    .i_ld_hi   (r_state == ST_S0),
    .i_ld_lo   (r_state == ST_S1),
    .i_data_in (bus.data_in),
    .o_ir      (w_ir)
  );

  assign w_op        = w_ir[2*DATA_W-1 -: OP_W];
  assign w_alu       = is_alu(w_op);
  assign w_sto       = (w_op == OP_STO);
  assign w_jmp       = (w_op == OP_JMP);
  assign w_skz_taken = (w_op == OP_SKZ) && r_zero_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Accumulator-zero snapshot taken at the end of S4 so later flag changes cannot alter a skip
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_zero_q <= 1'b0;
    else if (r_state == ST_S4) r_zero_q <= bus.zero;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = bus.ena ? ST_S0 : ST_IDLE;
      ST_S0:     w_next = ST_S1;
      ST_S1:     w_next = ST_S2;
      ST_S2:     w_next = ST_S3;
      ST_S3:     w_next = (w_op == OP_HLT) ? ST_HALTED : ST_S4;
      ST_S4:     w_next = ST_S5;
      ST_S5:     w_next = ST_S6;
      ST_S6:     w_next = ST_S7;
      ST_S7:     w_next = bus.ena ? ST_S0 : ST_IDLE;
      ST_HALTED: w_next = ST_HALTED;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Output decode from registered state, ir and zero snapshot only
  always_comb begin
    w_inc_pc      = 1'b0;
    w_load_pc     = 1'b0;
    w_rd          = 1'b0;
    w_wr          = 1'b0;
    w_load_acc    = 1'b0;
    w_datactl_ena = 1'b0;
    w_addr_sel    = 1'b0;
    w_halt        = 1'b0;
    case (r_state)
      ST_S0, ST_S1: begin
        w_rd     = 1'b1;
        w_inc_pc = 1'b1;
      end
      ST_S4: begin
        w_rd          = w_alu;
        w_datactl_ena = w_sto;
        w_addr_sel    = w_alu | w_sto;
        w_load_pc     = w_jmp;
      end
      ST_S5: begin
        w_rd          = w_alu;
        w_load_acc    = w_alu;
        w_wr          = w_sto;
        w_datactl_ena = w_sto;
        w_addr_sel    = w_alu | w_sto;
        w_inc_pc      = w_skz_taken;
      end
      ST_S6: begin
        w_datactl_ena = w_sto;
        w_addr_sel    = w_alu | w_sto;
      end
      ST_S7:     w_inc_pc = w_skz_taken;
      ST_HALTED: w_halt   = 1'b1;
      default: ;
    endcase
  end

  assign bus.opcode      = w_op;
  assign bus.ir_addr     = w_ir[ADDR_W-1:0];
  assign bus.inc_pc      = w_inc_pc;
  assign bus.load_pc     = w_load_pc;
  assign bus.rd          = w_rd;
  assign bus.wr          = w_wr;
  assign bus.load_acc    = w_load_acc;
  assign bus.datactl_ena = w_datactl_ena;
  assign bus.addr_sel    = w_addr_sel;
  assign bus.halt        = w_halt;

endmodule

// File: tb/tb_cpu_controller.sv
// Testbench for the instruction sequencer: directed programs followed by random traffic.
// Latency: outputs checked every cycle on the falling edge against a phase-level model.
// Backpressure: n/a.
module tb_cpu_controller;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  cpu_controller_if bus ();

  cpu_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase counter 0..7 plus idle/halted flags, the fetched word,
  // the zero snapshot, and a program counter advanced per whole instruction.
  bit          m_idle;
  bit          m_halted;
  int          m_phase;
  logic [15:0] m_ir;
  bit          m_zq;
  logic [12:0] m_pc;
  logic [12:0] obs_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] expect_vec();
    int op;
    bit alu, sto, jmp, skz_t, act;
    bit inc, ld, rdv, wrv, lacc, dctl, asel, hlt;
    op    = int'(m_ir[15:13]);
    alu   = (op >= 2 && op <= 5);
    sto   = (op == 6);
    jmp   = (op == 7);
    skz_t = (op == 1) && m_zq;
    act   = !m_idle && !m_halted;
    rdv   = act && ((m_phase <= 1) || (alu && (m_phase == 4 || m_phase == 5)));
    inc   = act && ((m_phase <= 1) || (skz_t && (m_phase == 5 || m_phase == 7)));
    ld    = act && jmp && m_phase == 4;
    wrv   = act && sto && m_phase == 5;
    lacc  = act && alu && m_phase == 5;
    dctl  = act && sto && m_phase >= 4 && m_phase <= 6;
    asel  = act && (alu || sto) && m_phase >= 4 && m_phase <= 6;
    hlt   = m_halted;
    return {m_ir[15:13], m_ir[12:0], inc, ld, rdv, wrv, lacc, dctl, asel, hlt};
  endfunction

  function automatic logic [23:0] obs_vec();
    return {bus.opcode, bus.ir_addr, bus.inc_pc, bus.load_pc, bus.rd, bus.wr,
            bus.load_acc, bus.datactl_ena, bus.addr_sel, bus.halt};
  endfunction

  task automatic check_outputs();
    string tag;
    tag = m_halted ? "out_halted" : (m_idle ? "out_idle" : $sformatf("out_phase%0d", m_phase));
    check(tag, {8'h0, obs_vec()}, {8'h0, expect_vec()});
    check("inc_and_load", {31'h0, bus.inc_pc & bus.load_pc}, 32'h0);
    check("rd_and_wr", {31'h0, bus.rd & bus.wr}, 32'h0);
    // PC as the downstream counter sees it: load wins over increment
    if (bus.load_pc)     obs_pc = bus.ir_addr;
    else if (bus.inc_pc) obs_pc = obs_pc + 13'd1;
  endtask

  task automatic model_update(input bit e, input logic [7:0] d, input bit z);
    int op;
    if (m_halted) begin
      // parked until reset
    end else if (m_idle) begin
      if (e) begin
        m_idle  = 0;
        m_phase = 0;
      end
    end else begin
      if (m_phase == 0) m_ir[15:8] = d;
      if (m_phase == 1) m_ir[7:0]  = d;
      if (m_phase == 4) m_zq       = z;
      op = int'(m_ir[15:13]);
      if (m_phase == 3 && op == 0) begin
        m_halted = 1;
      end else if (m_phase == 7) begin
        if (op == 7)                m_pc = m_ir[12:0];
        else if (op == 1 && m_zq)   m_pc = m_pc + 13'd4;
        else                        m_pc = m_pc + 13'd2;
        check("pc_after_instr", {19'h0, obs_pc}, {19'h0, m_pc});
        if (e) m_phase = 0;
        else   m_idle  = 1;
      end else begin
        m_phase++;
      end
    end
  endtask

  // One clock: check at the falling edge, drive inputs, advance model on the rising edge
  task automatic cycle(input bit e, input logic [7:0] d, input bit z);
    check_outputs();
    bus.ena     = e;
    bus.data_in = d;
    bus.zero    = z;
    @(posedge clk);
    model_update(e, d, z);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock
  task automatic do_reset();
    check_outputs();
    #2 rst = 1'b0;
    #1 check("async_reset_outputs", {8'h0, obs_vec()}, 32'h0);
    m_idle   = 1;
    m_halted = 0;
    m_phase  = 0;
    m_ir     = '0;
    m_zq     = 0;
    m_pc     = '0;
    obs_pc   = '0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  // Runs one instruction from S0; ena during S0..S6 is random and must be ignored
  task automatic instr(input logic [7:0] hi, input logic [7:0] lo, input bit z4,
                       input bit z_late, input bit ena_s7);
    cycle(bit'($urandom_range(0, 1)), hi, 1'b0);
    cycle(bit'($urandom_range(0, 1)), lo, 1'b0);
    cycle(bit'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    cycle(bit'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    cycle(bit'($urandom_range(0, 1)), 8'($urandom), z4);
    cycle(bit'($urandom_range(0, 1)), 8'($urandom), z_late);
    cycle(bit'($urandom_range(0, 1)), 8'($urandom), z_late);
    cycle(ena_s7, 8'($urandom), z_late);
  endtask

  initial begin
    int hcount;
    n_cmp       = 0;
    n_fail      = 0;
    rst         = 1'b0;
    bus.ena     = 1'b0;
    bus.data_in = '0;
    bus.zero    = 1'b0;
    m_idle = 1; m_halted = 0; m_phase = 0; m_ir = '0; m_zq = 0; m_pc = '0; obs_pc = '0;
    @(negedge clk);
    do_reset();

    // Idle with ena low, then start
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    // LDA 0x0ABC
    instr(8'hAA, 8'hBC, 1'b0, 1'b0, 1'b1);
    // JMP 0x1FFF
    instr(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    // SKZ taken
    instr(8'h20, 8'h00, 1'b1, 1'b1, 1'b1);
    // SKZ not taken, zero rises after the snapshot
    instr(8'h20, 8'h00, 1'b0, 1'b1, 1'b1);
    // STO, ena dropped in S7
    instr(8'hC0, 8'h05, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    // HLT, then ena toggling while halted
    instr(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(bit'(i & 1), 8'hFF, 1'b1);
    do_reset();
    cycle(1'b1, 8'h00, 1'b0);
    // ADD interrupted by reset while in S5
    cycle(1'b1, 8'h40, 1'b0);
    cycle(1'b1, 8'h12, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'h00, 1'b1);
    do_reset();
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);

    // Random traffic with periodic recovery from halt
    hcount = 0;
    for (int i = 0; i < 1500; i++) begin
      if (m_halted) hcount++;
      else          hcount = 0;
      if (hcount > 3 || $urandom_range(0, 199) == 0) begin
        do_reset();
        hcount = 0;
      end else begin
        cycle(bit'($urandom_range(0, 3) != 0), 8'($urandom), bit'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
